fir_coef_sched: RTL and testbench

Coefficient scheduler and flow gate for the FIR tap chain. It receives coefficient sets over an AXI-Stream port into a shadow bank, holds an active bank that drives every tap's `mult`/`multiplier_valid` pair, and forwards input samples to the head of the chain. Coefficient swaps are glitch-free: input is gated, the chain is drained, the active bank is swapped, then flow resumes. It sits between the sample source and tap 0, and also monitors the tail tap's output handshake.

---
 rtl/fir_ctrl_pkg.sv | 26 ++
 rtl/fir_coef_loader.sv | 94 +++++++++
 rtl/fir_coef_sched.sv | 107 ++++++++++
 tb/tb_fir_coef_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and helpers for the FIR coefficient scheduler.
// Holds FSM encodings, counter sizing and tap-slice addressing.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_RUN,
    ST_DRAIN,
    ST_SWAP
  } main_state_t;

  typedef enum logic [1:0] {
    LD_LOAD,
    LD_FULL,
    LD_SKIP
  } ld_state_t;

  function automatic int inflight_w(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

  function automatic int coef_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/fir_coef_loader.sv
// Shadow coefficient bank loader with set framing checks.
// Malformed sets raise a sticky error and are discarded.
module fir_coef_loader
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_TAPS   = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           coef_valid,
  output logic                           coef_ready,
  input  logic [DATA_WIDTH-1:0]          coef_data,
  input  logic                           coef_last,
  input  logic                           allow,
  input  logic                           swap,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] shadow,
  output logic                           full,
  output logic                           err
);

  localparam int XW = $clog2(NUM_TAPS);
  localparam logic [XW-1:0] LAST_IDX = XW'(NUM_TAPS - 1);

  ld_state_t       ld, ld_nx;
  logic [XW-1:0]   idx, idx_nx;
  logic            err_nx;
  logic            beat;
  logic            at_last;

  assign coef_ready = ((ld == LD_LOAD) || (ld == LD_SKIP)) && allow;
  assign beat       = coef_valid && coef_ready;
  assign at_last    = (idx == LAST_IDX);
  assign full       = (ld == LD_FULL);

  always_comb begin
    ld_nx  = ld;
    idx_nx = idx;
    err_nx = err;
    unique case (ld)
      LD_LOAD: begin
        if (beat) begin
          if (at_last) begin
            idx_nx = '0;
            if (coef_last) begin
              ld_nx = LD_FULL;
            end else begin
              err_nx = 1'b1;
              ld_nx  = LD_SKIP;
            end
          end else if (coef_last) begin
            err_nx = 1'b1;
            idx_nx = '0;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      LD_SKIP: begin
        if (beat && coef_last) ld_nx = LD_LOAD;
      end
      LD_FULL: begin
        if (swap) begin
          ld_nx  = LD_LOAD;
          idx_nx = '0;
        end
      end
      default: ld_nx = LD_LOAD;
    endcase
    if (swap) err_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld  <= LD_LOAD;
      idx <= '0;
      err <= 1'b0;
    end else begin
      ld  <= ld_nx;
      idx <= idx_nx;
      err <= err_nx;
    end
  end

  // Partial writes of a rejected set are harmless: full never rises for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (ld == LD_LOAD && beat) begin
      shadow[coef_lsb(int'(idx), DATA_WIDTH) +: DATA_WIDTH] <= coef_data;
    end
  end

endmodule

// File: rtl/fir_coef_sched.sv
// FIR coefficient scheduler: gates samples into tap 0, drains
// the chain and swaps the active coefficient bank glitch-free.
module fir_coef_sched
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_TAPS     = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_INFLIGHT = 64,
  localparam int IW          = inflight_w(MAX_INFLIGHT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_coef_tvalid,
  output logic                           s_coef_tready,
  input  logic [DATA_WIDTH-1:0]          s_coef_tdata,
  input  logic                           s_coef_tlast,
  input  logic                           commit,
  input  logic                           s_data_tvalid,
  output logic                           s_data_tready,
  input  logic [DATA_WIDTH-1:0]          s_data_tdata,
  output logic                           m_data_tvalid,
  input  logic                           m_data_tready,
  output logic [DATA_WIDTH-1:0]          m_data_tdata,
  input  logic                           tail_valid,
  input  logic                           tail_ready,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] tap_mult,
  output logic [NUM_TAPS-1:0]            tap_mult_valid,
  output logic                           active,
  output logic                           coef_err,
  output logic [IW-1:0]                  inflight
);

  localparam logic [IW-1:0] MAX_C = IW'(MAX_INFLIGHT);

  main_state_t st, st_nx;
  logic [NUM_TAPS*DATA_WIDTH-1:0] shadow;
  logic [NUM_TAPS*DATA_WIDTH-1:0] bank;
  logic full;
  logic swap;
  logic open;
  logic head;
  logic tail;

  assign swap = (st == ST_SWAP);

  fir_coef_loader #(
    .NUM_TAPS  (NUM_TAPS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .coef_valid(s_coef_tvalid),
    .coef_ready(s_coef_tready),
    .coef_data (s_coef_tdata),
    .coef_last (s_coef_tlast),
    .allow     (!((st == ST_DRAIN) || swap)),
    .swap      (swap),
    .shadow    (shadow),
    .full      (full),
    .err       (coef_err)
  );

  always_comb begin
    st_nx = st;
    unique case (st)
      ST_EMPTY: if (commit && full) st_nx = ST_SWAP;
      ST_RUN:   if (commit && full) st_nx = ST_DRAIN;
      ST_DRAIN: if (inflight == '0) st_nx = ST_SWAP;
      ST_SWAP:  st_nx = ST_RUN;
      default:  st_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) st <= ST_EMPTY;
    else     st <= st_nx;
  end

  assign open          = (st == ST_RUN) && (inflight < MAX_C);
  assign m_data_tvalid = s_data_tvalid && open;
  assign s_data_tready = m_data_tready && open;
  assign m_data_tdata  = s_data_tdata;

  assign head = s_data_tvalid && s_data_tready;
  assign tail = tail_valid && tail_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (head && !tail) begin
      inflight <= inflight + 1'b1;
    end else if (tail && !head && inflight != '0) begin
      inflight <= inflight - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       bank <= '0;
    else if (swap) bank <= shadow;
  end

  // Taps keep their multipliers while draining so in-flight samples finish.
  assign tap_mult       = bank;
  assign tap_mult_valid = {NUM_TAPS{(st == ST_RUN) || (st == ST_DRAIN)}};
  assign active         = (st == ST_RUN);

endmodule

// File: tb/tb_fir_coef_sched.sv
// Directed bench for fir_coef_sched: load, commit, drain/swap,
// malformed sets, in-flight saturation and reset during drain.
module tb_fir_coef_sched;

  localparam int NT = 8;
  localparam int DW = 32;
  localparam int MI = 64;
  localparam int IW = $clog2(MI + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              s_coef_tvalid;
  logic              s_coef_tready;
  logic [DW-1:0]     s_coef_tdata;
  logic              s_coef_tlast;
  logic              commit;
  logic              s_data_tvalid;
  logic              s_data_tready;
  logic [DW-1:0]     s_data_tdata;
  logic              m_data_tvalid;
  logic              m_data_tready;
  logic [DW-1:0]     m_data_tdata;
  logic              tail_valid;
  logic              tail_ready;
  logic [NT*DW-1:0]  tap_mult;
  logic [NT-1:0]     tap_mult_valid;
  logic              active;
  logic              coef_err;
  logic [IW-1:0]     inflight;

  int n_assert = 0;
  int n_fail   = 0;

  fir_coef_sched #(
    .NUM_TAPS    (NT),
    .DATA_WIDTH  (DW),
    .MAX_INFLIGHT(MI)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_coef_tvalid (s_coef_tvalid),
    .s_coef_tready (s_coef_tready),
    .s_coef_tdata  (s_coef_tdata),
    .s_coef_tlast  (s_coef_tlast),
    .commit        (commit),
    .s_data_tvalid (s_data_tvalid),
    .s_data_tready (s_data_tready),
    .s_data_tdata  (s_data_tdata),
    .m_data_tvalid (m_data_tvalid),
    .m_data_tready (m_data_tready),
    .m_data_tdata  (m_data_tdata),
    .tail_valid    (tail_valid),
    .tail_ready    (tail_ready),
    .tap_mult      (tap_mult),
    .tap_mult_valid(tap_mult_valid),
    .active        (active),
    .coef_err      (coef_err),
    .inflight      (inflight)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] coef(input int base, input int k);
    logic [15:0] h;
    h = 16'(base + k);
    return {h, h};
  endfunction

  function automatic logic [NT*DW-1:0] mk_set(input int base);
    logic [NT*DW-1:0] v;
    v = '0;
    for (int k = 0; k < NT; k++) v[k*DW +: DW] = coef(base, k);
    return v;
  endfunction

  task automatic beat(input logic [DW-1:0] d, input logic l);
    s_coef_tvalid = 1'b1;
    s_coef_tdata  = d;
    s_coef_tlast  = l;
    step();
    s_coef_tvalid = 1'b0;
    s_coef_tlast  = 1'b0;
  endtask

  task automatic load_set(input int base);
    for (int k = 0; k < NT; k++) beat(coef(base, k), k == NT - 1);
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  logic [NT*DW-1:0] set1;

  initial begin
    rst = 1'b1;
    s_coef_tvalid = 1'b0;
    s_coef_tdata = '0;
    s_coef_tlast = 1'b0;
    commit = 1'b0;
    s_data_tvalid = 1'b0;
    s_data_tdata = '0;
    m_data_tready = 1'b1;
    tail_valid = 1'b0;
    tail_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    s_data_tvalid = 1'b1;
    step();

    chk("rst_active", active, 1'b0);
    chk("rst_tmv", tap_mult_valid, '0);
    chk("rst_tap_mult", tap_mult, '0);
    chk("rst_m_tvalid", m_data_tvalid, 1'b0);
    chk("rst_s_tready", s_data_tready, 1'b0);
    chk("rst_coef_tready", s_coef_tready, 1'b1);
    chk("rst_inflight", inflight, '0);
    chk("rst_coef_err", coef_err, 1'b0);
    s_data_tvalid = 1'b0;

    // set 1, commit coincident with tlast is ignored
    for (int k = 0; k < NT - 1; k++) beat(coef(1, k), 1'b0);
    commit = 1'b1;
    beat(coef(1, NT - 1), 1'b1);
    commit = 1'b0;
    chk("full_tready", s_coef_tready, 1'b0);
    step();
    chk("tlast_commit_ign", active, 1'b0);
    pulse_commit();
    chk("swap_active", active, 1'b0);
    chk("swap_tmv", tap_mult_valid, '0);
    step();
    set1 = mk_set(1);
    chk("run_active", active, 1'b1);
    chk("run_tmv", tap_mult_valid, 8'hff);
    chk("run_set1", tap_mult, set1);
    chk("set1_slice7", tap_mult[7*DW +: DW], 32'h0008_0008);
    chk("run_coef_tready", s_coef_tready, 1'b1);

    // 5 samples into the chain
    s_data_tvalid = 1'b1;
    s_data_tdata  = 32'hdead_beef;
    #1;
    chk("pass_tdata", m_data_tdata, 32'hdead_beef);
    chk("pass_tvalid", m_data_tvalid, 1'b1);
    chk("pass_tready", s_data_tready, 1'b1);
    m_data_tready = 1'b0;
    #1;
    chk("bp_tready", s_data_tready, 1'b0);
    m_data_tready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    s_data_tvalid = 1'b0;
    chk("inflight5", inflight, 7'd5);

    load_set(32'h20);
    chk("set2_full", s_coef_tready, 1'b0);
    chk("set2_bank_hold", tap_mult, set1);
    pulse_commit();
    s_data_tvalid = 1'b1;
    #1;
    chk("drain_s_tready", s_data_tready, 1'b0);
    chk("drain_m_tvalid", m_data_tvalid, 1'b0);
    chk("drain_tmv", tap_mult_valid, 8'hff);
    s_data_tvalid = 1'b0;
    tail_valid = 1'b1;
    tail_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    tail_valid = 1'b0;
    tail_ready = 1'b0;
    chk("drain_done_inf", inflight, '0);
    chk("drain_bank_hold", tap_mult, set1);
    step();
    chk("swap2_tmv", tap_mult_valid, '0);
    step();
    chk("run2_set", tap_mult, mk_set(32'h20));
    chk("run2_active", active, 1'b1);
    chk("run2_s_tready", s_data_tready, 1'b1);

    // short set: tlast on beat 3
    beat(coef(32'h40, 0), 1'b0);
    beat(coef(32'h40, 1), 1'b0);
    beat(coef(32'h40, 2), 1'b1);
    chk("short_err", coef_err, 1'b1);
    chk("short_tready", s_coef_tready, 1'b1);
    pulse_commit();
    chk("short_commit_ign", active, 1'b1);
    load_set(32'h50);
    pulse_commit();
    step();
    step();
    chk("short_recover_set", tap_mult, mk_set(32'h50));
    chk("short_err_clear", coef_err, 1'b0);

    // long set: 10 beats, tlast on the 10th
    for (int k = 0; k < NT; k++) beat(coef(32'h60, k), 1'b0);
    chk("long_err", coef_err, 1'b1);
    chk("skip_tready", s_coef_tready, 1'b1);
    beat(coef(32'h60, 8), 1'b0);
    beat(coef(32'h60, 9), 1'b1);
    chk("long_bank_hold", tap_mult, mk_set(32'h50));
    load_set(32'h70);
    chk("long_next_full", s_coef_tready, 1'b0);
    pulse_commit();
    step();
    step();
    chk("long_next_set", tap_mult, mk_set(32'h70));
    chk("long_err_clear", coef_err, 1'b0);

    // fill to MAX_INFLIGHT with tail stalled
    s_data_tvalid = 1'b1;
    tail_valid = 1'b1;
    tail_ready = 1'b0;
    for (int i = 0; i < MI; i++) step();
    chk("sat_inflight", inflight, 7'd64);
    chk("sat_s_tready", s_data_tready, 1'b0);
    chk("sat_m_tvalid", m_data_tvalid, 1'b0);
    step();
    chk("sat_hold", inflight, 7'd64);
    s_data_tvalid = 1'b0;
    tail_ready = 1'b1;
    step();
    tail_ready = 1'b0;
    chk("sat_dec", inflight, 7'd63);
    chk("sat_reopen", s_data_tready, 1'b1);
    s_data_tvalid = 1'b1;
    tail_ready = 1'b1;
    step();
    chk("sat_both", inflight, 7'd63);
    tail_ready = 1'b0;
    step();
    chk("sat_refill", inflight, 7'd64);
    s_data_tvalid = 1'b0;

    // reset while draining
    load_set(32'h90);
    pulse_commit();
    chk("pre_rst_drain", tap_mult_valid, 8'hff);
    chk("pre_rst_active", active, 1'b0);
    rst = 1'b1;
    step();
    chk("mid_rst_active", active, 1'b0);
    chk("mid_rst_tmv", tap_mult_valid, '0);
    chk("mid_rst_tap_mult", tap_mult, '0);
    chk("mid_rst_inflight", inflight, '0);
    chk("mid_rst_err", coef_err, 1'b0);
    chk("mid_rst_s_tready", s_data_tready, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_coef_tready", s_coef_tready, 1'b1);
    chk("post_rst_active", active, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
